dbg_inject: RTL

Debug stimulus injector for the hero game: the write-side counterpart of the on-chip logic-analyzer capture path. A UART byte stream from the host is parsed into short command frames. The frames force the hero selection and generate timed button pulses into the game FSM's input path, so the bench and board bring-up can drive scenarios that the analyzer then observes. It sits between the board RX pin and the game's input multiplexer, in the `clk` domain.

---
 rtl/dbg_inject_pkg.sv | 12 +
 rtl/uart_rx_byte.sv | 90 +++++++++
 rtl/dbg_inject.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dbg_inject_pkg.sv
// rtl/dbg_inject_pkg.sv - frame constants, command codes and state encodings for dbg_inject
package dbg_inject_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_HERO = 8'h01;
  localparam logic [7:0] CMD_PULSE    = 8'h02;
  localparam logic [7:0] CMD_RELEASE  = 8'h03;

  typedef enum logic [1:0] {P_IDLE, P_CMD, P_DATA, P_CHK} pstate_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with 2-flop synchronizer and glitch rejection
module uart_rx_byte
  import dbg_inject_pkg::*;
#(
  parameter int DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int CW = $clog2(DIV);

  logic          s1_q, s2_q, prev_q;
  rstate_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_d, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_o <= valid_d;
      err_o   <= err_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) st_d = R_START;
      end
      R_START: begin
        // Line back high at mid-start means a glitch, not a start bit.
        if (cnt_q == CW'(DIV / 2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          valid_d = s2_q;
          err_d   = !s2_q;
          st_d    = R_IDLE;
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

  assign data_o = sh_q;

endmodule

// File: rtl/dbg_inject.sv
// rtl/dbg_inject.sv - UART command-frame parser driving hero override and button pulses
// Define DBG_INJECT_CHK_EN to require a trailing XOR checksum byte on every frame.
module dbg_inject
  import dbg_inject_pkg::*;
#(
  parameter int CLK_HZ         = 27_000_000,
  parameter int BAUD           = 115200,
  parameter int PULSE_CYCLES   = 2_700_000,
  parameter int TIMEOUT_CYCLES = 23_400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       ovr_en_o,
  output logic [2:0] heroe_ovr_o,
  output logic [3:0] boton_o,
  output logic       cmd_valid_o,
  output logic       frame_err_o
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int PW  = $clog2(PULSE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_i),
    .data_o (rx_data),
    .valid_o(rx_valid),
    .err_o  (rx_err)
  );

  pstate_e       p_q, p_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          ovr_q, ovr_d, cv_q, cv_d, fe_q, fe_d, exec;
  logic [2:0]    hero_q, hero_d, ex_hero;
  logic [3:0]    bt_q, bt_d, ex_mask;
  logic          ex_ovr;

`ifdef DBG_INJECT_CHK_EN
  logic [7:0] data_q, data_d;
  assign ex_hero = data_q[2:0];
  assign ex_ovr  = data_q[7];
  assign ex_mask = data_q[3:0];
`else
  assign ex_hero = rx_data[2:0];
  assign ex_ovr  = rx_data[7];
  assign ex_mask = rx_data[3:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= P_IDLE;
      cmd_q  <= '0;
      to_q   <= '0;
      pc_q   <= '0;
      ovr_q  <= 1'b0;
      hero_q <= '0;
      bt_q   <= '0;
      cv_q   <= 1'b0;
      fe_q   <= 1'b0;
`ifdef DBG_INJECT_CHK_EN
      data_q <= '0;
`endif
    end else begin
      p_q    <= p_d;
      cmd_q  <= cmd_d;
      to_q   <= to_d;
      pc_q   <= pc_d;
      ovr_q  <= ovr_d;
      hero_q <= hero_d;
      bt_q   <= bt_d;
      cv_q   <= cv_d;
      fe_q   <= fe_d;
`ifdef DBG_INJECT_CHK_EN
      data_q <= data_d;
`endif
    end
  end

  always_comb begin
    p_d    = p_q;
    cmd_d  = cmd_q;
    pc_d   = pc_q;
    ovr_d  = ovr_q;
    hero_d = hero_q;
    bt_d   = bt_q;
    cv_d   = 1'b0;
    fe_d   = 1'b0;
    exec   = 1'b0;
    to_d   = (p_q == P_IDLE || rx_valid) ? '0 : to_q + 1'b1;
`ifdef DBG_INJECT_CHK_EN
    data_d = data_q;
`endif
    if (pc_q != '0) begin
      pc_d = pc_q - 1'b1;
      if (pc_q == PW'(1)) bt_d = '0;
    end

    if (rx_err) begin
      fe_d = 1'b1;
      p_d  = P_IDLE;
    end else if (rx_valid) begin
      case (p_q)
        P_IDLE: if (rx_data == SYNC_BYTE) p_d = P_CMD;
        P_CMD: begin
          cmd_d = rx_data;
          p_d   = P_DATA;
        end
`ifdef DBG_INJECT_CHK_EN
        P_DATA: begin
          data_d = rx_data;
          p_d    = P_CHK;
        end
        P_CHK: begin
          p_d = P_IDLE;
          if (rx_data == (SYNC_BYTE ^ cmd_q ^ data_q)) exec = 1'b1;
          else fe_d = 1'b1;
        end
`else
        P_DATA: begin
          exec = 1'b1;
          p_d  = P_IDLE;
        end
`endif
        default: p_d = P_IDLE;
      endcase
    end else if (p_q != P_IDLE && to_q == TW'(TIMEOUT_CYCLES)) begin
      fe_d = 1'b1;
      p_d  = P_IDLE;
      to_d = '0;
    end

    // A new PULSE overrides any pending pulse and restarts its width.
    if (exec) begin
      case (cmd_q)
        CMD_SET_HERO: begin
          hero_d = ex_hero;
          ovr_d  = ex_ovr;
          cv_d   = 1'b1;
        end
        CMD_PULSE: begin
          bt_d = ex_mask;
          pc_d = PW'(PULSE_CYCLES);
          cv_d = 1'b1;
        end
        CMD_RELEASE: begin
          ovr_d  = 1'b0;
          hero_d = '0;
          bt_d   = '0;
          pc_d   = '0;
          cv_d   = 1'b1;
        end
        default: fe_d = 1'b1;
      endcase
    end
  end

  assign ovr_en_o    = ovr_q;
  assign heroe_ovr_o = hero_q;
  assign boton_o     = bt_q;
  assign cmd_valid_o = cv_q;
  assign frame_err_o = fe_q;

endmodule
